// File: rtl/mem_bist_wb_if.sv
// Wishbone classic bus between the BIST master and the SRAM slave.
// Member names keep the master-side port names of the BIST engine.
interface mem_bist_wb_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/mem_bist_wb.sv
// SRAM BIST engine: writes a seeded pattern over a word window through Wishbone,
// reads it back, and reports error count plus the first failing address/data.
//
// state  | meaning
// IDLE   | waiting for start after reset
// WR_REQ | write strobe active for word idx
// WR_GAP | one idle cycle after a write ack
// RD_REQ | read strobe active for word idx, compare on ack
// RD_GAP | one idle cycle after a read ack
// DONE   | results held until next start
module mem_bist_wb #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [31:0]          seed_i,
  mem_bist_wb_if.master        wbm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [15:0]          err_cnt_o,
  output logic [31:0]          fail_addr_o,
  output logic [31:0]          fail_data_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_GAP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_GAP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(MEM_WORDS - 1);
  localparam logic [7:0]  TMR_LOAD = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] err_q, err_d;
  logic [31:0] fail_addr_q, fail_addr_d;
  logic [31:0] fail_data_q, fail_data_d;
  logic        tout_q, tout_d;

  logic [31:0] pat;
  logic [31:0] adr_w;
  logic        in_req;

  function automatic logic [31:0] pattern(input logic [1:0] m, input logic [31:0] s,
                                          input logic [15:0] i);
    logic [31:0] ix;
    ix = {16'h0000, i};
    case (m)
      2'b00:   pattern = s;
      2'b01:   pattern = s ^ ix;
      2'b10:   pattern = i[0] ? ~s : s;
      default: pattern = ~(s ^ ix);
    endcase
  endfunction

  assign pat    = pattern(mode_q, seed_q, idx_q);
  assign adr_w  = ADDR_BASE + {14'b0, idx_q, 2'b00};
  assign in_req = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      tout_q      <= tout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    tout_d      = tout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_WR_REQ;
          mode_d      = mode_i;
          seed_d      = seed_i;
          idx_d       = '0;
          tmr_d       = TMR_LOAD;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          tout_d      = 1'b0;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        // An ack in the terminal-count cycle still completes the transfer.
        if (wbm.wbm_ack_i) begin
          state_d = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
          if ((state_q == S_RD_REQ) && (wbm.wbm_dat_i != pat)) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'h0000) begin
              fail_addr_d = adr_w;
              fail_data_d = wbm.wbm_dat_i;
            end
          end
        end else if (tmr_q == 8'd0) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_WR_GAP: begin
        tmr_d = TMR_LOAD;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_WR_REQ;
        end
      end
      S_RD_GAP: begin
        tmr_d = TMR_LOAD;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wbm.wbm_cyc_o = in_req;
    wbm.wbm_stb_o = in_req;
    wbm.wbm_we_o  = (state_q == S_WR_REQ);
    wbm.wbm_sel_o = in_req ? 4'hF : 4'h0;
    wbm.wbm_adr_o = in_req ? adr_w : 32'h0;
    wbm.wbm_dat_o = (state_q == S_WR_REQ) ? pat : 32'h0;
    busy_o        = (state_q == S_WR_REQ) || (state_q == S_WR_GAP) ||
                    (state_q == S_RD_REQ) || (state_q == S_RD_GAP);
    done_o        = (state_q == S_DONE);
    pass_o        = (state_q == S_DONE) && (err_q == 16'h0000) && !tout_q;
    timeout_o     = tout_q;
    err_cnt_o     = err_q;
    fail_addr_o   = fail_addr_q;
    fail_data_o   = fail_data_q;
  end

endmodule

// File: tb/tb_mem_bist_wb.sv
// Directed bench for mem_bist_wb: SRAM slave model with fault/no-ack hooks,
// transaction scoreboard and a protocol monitor.
module tb_mem_bist_wb;
  localparam int unsigned NW    = 256;
  localparam int          LAT_R = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, pass, tout;
  logic [15:0] err_cnt;
  logic [31:0] fail_addr, fail_data;

  mem_bist_wb_if bus ();

  mem_bist_wb #(.MEM_WORDS(NW), .ADDR_BASE(32'h0), .TIMEOUT(15)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .seed_i      (seed),
    .wbm         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .timeout_o   (tout),
    .err_cnt_o   (err_cnt),
    .fail_addr_o (fail_addr),
    .fail_data_o (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  txn_t sb_q[$];
  logic [31:0] mem [NW];
  logic [31:0] last_rd [NW];
  logic fault_en = 1'b0;
  logic noack_en = 1'b0;
  int   wait_q   = 0;
  int   proto_err = 0;
  int   stb_c_cnt = 0;
  logic prev_ack = 1'b0, prev_stb = 1'b0, prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", name, obs, exp);
  endtask

  function automatic logic [31:0] model_pat(input logic [1:0] m, input logic [31:0] s, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    case (m)
      2'b00: return s;
      2'b01: return s ^ iv;
      2'b10: return (i % 2 == 1) ? ~s : s;
      default: return ~(s ^ iv);
    endcase
  endfunction

  // SRAM slave: registered ack, never back-to-back, optional read fault / missing ack.
  always @(posedge clk) begin
    bus.wbm_ack_i <= 1'b0;
    if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
      if (wait_q < (bus.wbm_we_o ? 0 : LAT_R)) begin
        wait_q <= wait_q + 1;
      end else if (!(noack_en && bus.wbm_we_o && bus.wbm_adr_o == 32'hC)) begin
        bus.wbm_ack_i <= 1'b1;
        wait_q        <= 0;
        if (bus.wbm_we_o) mem[bus.wbm_adr_o[9:2]] <= bus.wbm_dat_o;
        else if (fault_en && (bus.wbm_adr_o[9:2] == 8'd5 || bus.wbm_adr_o[9:2] == 8'd9))
          bus.wbm_dat_i <= mem[bus.wbm_adr_o[9:2]] ^ 32'h0000_0080;
        else
          bus.wbm_dat_i <= mem[bus.wbm_adr_o[9:2]];
      end
    end else begin
      wait_q <= 0;
    end
  end

  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
      prev_stb = 1'b0;
    end else begin
      if (bus.wbm_stb_o && prev_ack) proto_err++;
      if (bus.wbm_stb_o && bus.wbm_sel_o != 4'hF) proto_err++;
      if (!bus.wbm_stb_o && bus.wbm_sel_o != 4'h0) proto_err++;
      if (bus.wbm_stb_o && prev_stb && bus.wbm_we_o != prev_we) proto_err++;
      if (bus.wbm_stb_o && bus.wbm_we_o && bus.wbm_adr_o == 32'hC) stb_c_cnt++;
      if (bus.wbm_stb_o && bus.wbm_ack_i) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $error("FAIL sb_underflow: got unexpected ack at adr %h expected none", bus.wbm_adr_o);
        end else begin
          txn_t t;
          t = sb_q.pop_front();
          check("sb_we",  32'(bus.wbm_we_o), 32'(t.we));
          check("sb_adr", bus.wbm_adr_o, t.adr);
          check("sb_dat", bus.wbm_dat_o, t.dat);
          if (!bus.wbm_we_o) last_rd[bus.wbm_adr_o[9:2]] = bus.wbm_dat_i;
        end
      end
      prev_ack = bus.wbm_ack_i;
      prev_stb = bus.wbm_stb_o;
      prev_we  = bus.wbm_we_o;
    end
  end

  task automatic run_start(input logic [1:0] m, input logic [31:0] s);
    sb_q.delete();
    for (int i = 0; i < int'(NW); i++) sb_q.push_back('{1'b1, 32'(4 * i), model_pat(m, s, i)});
    for (int i = 0; i < int'(NW); i++) sb_q.push_back('{1'b0, 32'(4 * i), 32'h0});
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(err_cnt), 32'd0);
    check("start_fadr_clr", fail_addr, 32'd0);
    check("start_tout_clr", 32'(tout), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    seed  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    check("rst_adr", bus.wbm_adr_o, 32'd0);
    rst_n = 1'b1;

    // Clean run.
    proto_err = 0;
    run_start(2'b01, 32'hA5A5_0000);
    wait_done(4000);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_cnt), 32'd0);
    check("clean_mem3", mem[3], 32'hA5A5_0003);
    check("clean_sb_left", 32'(sb_q.size()), 32'd0);
    check("clean_proto", 32'(proto_err), 32'd0);

    // Bit-7 read faults at words 5 and 9.
    fault_en = 1'b1;
    run_start(2'b00, 32'h1234_5678);
    wait_done(4000);
    fault_en = 1'b0;
    check("flt_err", 32'(err_cnt), 32'd2);
    check("flt_addr", fail_addr, 32'd20);
    check("flt_data", fail_data, 32'h1234_56F8);
    check("flt_pass", 32'(pass), 32'd0);

    // Restart after a failing run; a mid-run start pulse must be ignored.
    run_start(2'b10, 32'hFFFF_0000);
    repeat (20) @(negedge clk);
    start = 1'b1;
    mode  = 2'b00;
    seed  = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done(4000);
    check("m10_pass", 32'(pass), 32'd1);
    check("m10_rd1", last_rd[1], 32'h0000_FFFF);
    check("m10_rd0", last_rd[0], 32'hFFFF_0000);
    check("m10_sb_left", 32'(sb_q.size()), 32'd0);

    // Missing ack on the 4th write.
    noack_en  = 1'b1;
    stb_c_cnt = 0;
    run_start(2'b01, 32'h0);
    wait_done(200);
    noack_en = 1'b0;
    check("to_stb_cycles", 32'(stb_c_cnt), 32'd15);
    check("to_timeout", 32'(tout), 32'd1);
    check("to_pass", 32'(pass), 32'd0);
    check("to_stb_low", 32'(bus.wbm_stb_o), 32'd0);
    check("to_sb_left", 32'(sb_q.size()), 32'(2 * NW - 3));

    // Reset in the middle of the read of word 100.
    run_start(2'b11, 32'h5A5A_1234);
    n = 0;
    while (!(bus.wbm_stb_o && !bus.wbm_we_o && bus.wbm_adr_o == 32'd400) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("mid_found", 32'(bus.wbm_adr_o), 32'd400);
    #2 rst_n = 1'b0;
    #1;
    check("mid_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("mid_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    proto_err = 0;
    run_start(2'b11, 32'h5A5A_1234);
    wait_done(4000);
    check("rerun_pass", 32'(pass), 32'd1);
    check("rerun_sb_left", 32'(sb_q.size()), 32'd0);
    check("rerun_proto", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
